// File: rtl/quant_stream_pkg.sv
// Shared types and helpers for the int8 quantized stream producer.
// Helpers take 32-bit/int operands so one package serves every parameterisation.
package quant_stream_pkg;

    typedef enum logic [1:0] {FILL, CALC, DRAIN} quant_state_t;

    // Index of the most significant set bit plus one; zero for a zero value.
    function automatic int bit_length(input logic [31:0] value);
        int len;
        len = 0;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) len = i + 1;
        end
        return len;
    endfunction

    // Symmetric clamp: the most negative code is never produced.
    function automatic int sat_signed(input int value, input int width);
        int lim;
        lim = (1 << (width - 1)) - 1;
        if (value > lim) return lim;
        if (value < -lim) return -lim;
        return value;
    endfunction

endpackage

// File: rtl/beat_absmax.sv
// Folds the magnitudes of one input beat into the running block absmax.
module beat_absmax #(
    parameter int IN_WIDTH  = 16,
    parameter int NUM_ELEMS = 4
) (
    input  logic [IN_WIDTH-1:0] beat [NUM_ELEMS],
    input  logic [IN_WIDTH-1:0] absmax_in,
    output logic [IN_WIDTH-1:0] absmax_out
);

    logic [IN_WIDTH-1:0] mag;

    // Magnitude is unsigned, so the most negative input maps to 2^(IN_WIDTH-1).
    always_comb begin
        absmax_out = absmax_in;
        mag = '0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            mag = beat[i][IN_WIDTH-1] ? (~beat[i] + IN_WIDTH'(1)) : beat[i];
            if (mag > absmax_out) absmax_out = mag;
        end
    end

endmodule

// File: rtl/blockwise_absmax_quantizer.sv
// Buffers a block of beats, derives one power-of-two scale from its absmax,
// then replays the block as saturated narrow integers tagged with that scale.
import quant_stream_pkg::*;

module blockwise_absmax_quantizer #(
    parameter int IN_WIDTH           = 16,
    parameter int IN_SIZE            = 1,
    parameter int IN_PARALLELISM     = 4,
    parameter int IN_DEPTH           = 3,
    parameter int QUANTIZATION_WIDTH = 8,
    parameter int SHIFT_WIDTH        = $clog2(IN_WIDTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_WIDTH-1:0]           data_in [IN_PARALLELISM*IN_SIZE],
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic [QUANTIZATION_WIDTH-1:0] data_out [IN_PARALLELISM*IN_SIZE],
    output logic [IN_WIDTH-1:0]           max_num,
    output logic [SHIFT_WIDTH-1:0]        shift,
    output logic                          data_out_valid,
    input  logic                          data_out_ready
);

    localparam int NUM   = IN_PARALLELISM * IN_SIZE;
    localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

    quant_state_t            state, next_state;
    logic [CNT_W-1:0]        cnt;
    logic [IN_WIDTH-1:0]     absmax, absmax_next;
    logic [IN_WIDTH-1:0]     buffer [IN_DEPTH][NUM];
    logic [SHIFT_WIDTH-1:0]  shift_calc;
    logic signed [IN_WIDTH-1:0] shifted;
    int                      blen;
    logic                    in_fire, out_fire, last_beat;

    assign in_fire   = data_in_valid && (state == FILL);
    assign out_fire  = data_out_ready && (state == DRAIN);
    assign last_beat = (cnt == CNT_W'(IN_DEPTH - 1));

    beat_absmax #(
        .IN_WIDTH  (IN_WIDTH),
        .NUM_ELEMS (NUM)
    ) u_beat_absmax (
        .beat       (data_in),
        .absmax_in  (absmax),
        .absmax_out (absmax_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FILL;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL:    if (in_fire && last_beat) next_state = CALC;
            CALC:    next_state = DRAIN;
            DRAIN:   if (out_fire && last_beat) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    // Keep the top QUANTIZATION_WIDTH-1 magnitude bits; the sign bit is the last one.
    always_comb begin
        blen = bit_length(32'(absmax));
        shift_calc = (blen > QUANTIZATION_WIDTH - 1)
                   ? SHIFT_WIDTH'(blen - (QUANTIZATION_WIDTH - 1)) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            absmax  <= '0;
            shift   <= '0;
            max_num <= '0;
        end else begin
            case (state)
                FILL: if (in_fire) begin
                    absmax <= absmax_next;
                    cnt    <= last_beat ? '0 : cnt + CNT_W'(1);
                end
                CALC: begin
                    shift   <= shift_calc;
                    max_num <= absmax;
                end
                DRAIN: if (out_fire) begin
                    if (last_beat) begin
                        cnt    <= '0;
                        absmax <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) buffer[cnt] <= data_in;
    end

    always_comb begin
        data_in_ready  = (state == FILL);
        data_out_valid = (state == DRAIN);
        shifted = '0;
        for (int i = 0; i < NUM; i++) begin
            shifted = $signed(buffer[cnt][i]) >>> shift;
            data_out[i] = data_out_valid
                        ? QUANTIZATION_WIDTH'(sat_signed(int'(shifted), QUANTIZATION_WIDTH))
                        : '0;
        end
    end

endmodule
